// File: rtl/fft4_reorder_if.sv
// Stream bundle for the 4-point FFT output reorder buffer.
// slave: the reorder buffer; master: the producer/consumer side.
interface fft4_reorder_if #(
  parameter int n = 8
);
  logic         in_valid;
  logic         in_sof;
  logic [n-1:0] in_data;
  logic         in_ready;
  logic [n-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_idx;
  logic         out_last;
  logic         frame_err;

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, y, out_valid, out_idx, out_last, frame_err
  );

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, y, out_valid, out_idx, out_last, frame_err
  );
endinterface

// File: rtl/fft4_reorder.sv
// Bit-reversed to natural order reorder buffer for a 4-point FFT.
// FFT4_REORDER_PINGPONG_EN selects two banks instead of one.
module fft4_reorder #(
  parameter int n = 8
) (
  input  logic          clk,
  input  logic          clear,
  fft4_reorder_if.slave bus
);
`ifdef FFT4_REORDER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam logic TGL = (NB == 2) ? 1'b1 : 1'b0;

  logic [n-1:0]  r_mem [NB][4];
  logic [NB-1:0] r_full;
  logic [1:0]    r_wc;
  logic [1:0]    r_rc;
  logic          r_wb;
  logic          r_rb;
  logic          r_err;

  logic          w_in_hs;
  logic          w_out_hs;
  logic          w_wdone;
  logic          w_rdone;
  logic [1:0]    w_wpos;
  logic [1:0]    w_waddr;
  logic [NB-1:0] w_full_nxt;

  assign bus.in_ready  = ~r_full[r_wb];
  assign bus.out_valid = r_full[r_rb];
  assign bus.y         = r_mem[r_rb][r_rc];
  assign bus.out_idx   = r_rc;
  assign bus.out_last  = r_full[r_rb] && (r_rc == 2'd3);
  assign bus.frame_err = r_err;

  assign w_in_hs  = bus.in_valid && ~r_full[r_wb];
  assign w_out_hs = r_full[r_rb] && bus.out_ready;

  // A start-of-frame marker always restarts capture at position 0.
  assign w_wpos  = bus.in_sof ? 2'd0 : r_wc;
  assign w_waddr = {w_wpos[0], w_wpos[1]};
  assign w_wdone = w_wpos == 2'd3;
  assign w_rdone = r_rc == 2'd3;

  always_comb begin
    w_full_nxt = r_full;
    if (w_in_hs && w_wdone) w_full_nxt[r_wb] = 1'b1;
    if (w_out_hs && w_rdone) w_full_nxt[r_rb] = 1'b0;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int b = 0; b < NB; b++)
        for (int a = 0; a < 4; a++)
          r_mem[b][a] <= '0;
      r_full <= '0;
      r_wc   <= 2'd0;
      r_rc   <= 2'd0;
      r_wb   <= 1'b0;
      r_rb   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      r_err  <= w_in_hs && bus.in_sof && (r_wc != 2'd0);
      if (w_in_hs) begin
        r_mem[r_wb][w_waddr] <= bus.in_data;
        r_wc <= w_wpos + 2'd1;
        if (w_wdone) r_wb <= r_wb ^ TGL;
      end
      if (w_out_hs) begin
        r_rc <= r_rc + 2'd1;
        if (w_rdone) r_rb <= r_rb ^ TGL;
      end
    end
  end
endmodule

// File: doc/fft4_reorder.md
# fft4_reorder

Output reorder buffer that sits directly downstream of the 4-point pipelined FFT stage. It takes the stage's serial output stream in bit-reversed order (bins 0, 2, 1, 3), collects each 4-sample frame, and emits it in natural order (0, 1, 2, 3) on a valid/ready interface. Frame storage is optionally double-buffered so that capture and drain can overlap.

## Interface

Parameters:
- n, 8, sample width in bits; matches the FFT datapath width.

Ports:
- clk  input  1  single clock, rising-edge.
- clear  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a valid FFT output sample.
- in_sof  input  1  qualifies the current in_data as the first sample of a frame.
- in_data  input  n  FFT output sample, bit-reversed order.
- in_ready  output  1  the buffer can accept in_data this cycle.
- y  output  n  reordered sample, natural order.
- out_valid  output  1  y is valid.
- out_ready  input  1  the consumer accepts y this cycle.
- out_idx  output  2  bin index of y, 0..3.
- out_last  output  1  high when out_idx==3 and out_valid.
- frame_err  output  1  one-cycle pulse when a frame is abandoned by a mid-frame in_sof.

## Operation

- Storage: 4 entries of n bits per bank. There are 2 banks with FFT4_REORDER_PINGPONG_EN, otherwise 1. Each bank has a full flag.
- Write side:
  - An input handshake is in_valid && in_ready.
  - Write counter wc (0..3). The sample at input position wc is written to address rev(wc): 0→0, 1→2, 2→1, 3→3.
  - On the handshake at wc==3, set full[wr_bank], toggle wr_bank (ping-pong only) and reset wc to 0.
  - in_ready = ~full[wr_bank].
- Sync:
  - in_sof on a handshake with wc!=0: the partial frame is discarded, the sample is written as position 0, wc becomes 1, and frame_err pulses the next cycle.
  - in_sof at wc==0 is normal.
  - in_sof is not mandatory; an unmarked sample at wc==0 starts a frame.
- Read side:
  - out_valid = full[rd_bank].
  - y = mem[rd_bank][rc] (combinational mux from registered storage); out_idx = rc.
  - An output handshake is out_valid && out_ready. It increments rc.
  - On the handshake at rc==3: clear full[rd_bank], toggle rd_bank (ping-pong only), rc becomes 0.
- Simultaneous events:
  - Set of one bank's full flag and clear of the other bank's full flag in the same cycle are both applied.
  - Single-bank mode: set and clear cannot coincide, because in_ready is low while the bank is full.
- Arithmetic: pure data movement, no width change. Counters wrap modulo 4.

## Timing

- Reset values (asynchronous, while clear==0): wc=0, rc=0, wr_bank=0, rd_bank=0, all full=0, storage=0. This gives in_ready=1, out_valid=0, y=0, out_idx=0, out_last=0, frame_err=0.
- Latency: last input sample accepted at cycle t → out_valid=1 with bin 0 at cycle t+1.
- Throughput:
  - Ping-pong: 1 sample/cycle sustained in and out.
  - Single bank: 4 input cycles, then at least 4 drain cycles. in_ready returns to 1 the cycle after the out_last handshake.
- Backpressure: while out_valid && !out_ready, y, out_idx and out_last hold stable.
- Reset mid-frame or mid-drain: all frame contents are lost and outputs go to reset values immediately.

## Configuration

- FFT4_REORDER_PINGPONG_EN defined: two banks; capture of frame k+1 overlaps drain of frame k.
- FFT4_REORDER_PINGPONG_EN undefined: one bank; wr_bank and rd_bank are held at 0; in_ready is low for the whole drain.

## Test plan

- Reset: hold clear=0 with random inputs → in_ready=1, out_valid=0, y=0, out_idx=0, out_last=0, frame_err=0.
- Single frame: in_data 10, 20, 30, 40 on consecutive cycles (sof on 10), out_ready=1 → y=10, 30, 20, 40 with out_idx 0..3 and out_last on 40. out_valid rises the cycle after 40 is accepted.
- Back-to-back (ping-pong): two frames in 8 consecutive cycles, out_ready=1 → in_ready never drops and 8 outputs are contiguous.
  - Without the macro: in_ready is low for exactly 4 cycles after frame 1.
- Backpressure: out_ready=0 for 3 cycles while out_idx=1 → y holds 30 and out_idx holds 1; the sequence resumes unchanged.
- Resync: 2 samples, then in_sof with 50, 60, 70, 80 → frame_err pulses once; output is 50, 70, 60, 80; nothing from the partial frame is emitted.
- Reset mid-drain: assert clear at out_idx=2 → out_valid=0 and y=0 immediately; after release, a fresh frame reorders correctly.
